// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle FETCH/DECODE/EXEC/WB control unit for a small RV32
//               subset (ADD, SUB, ADDI, BNE, LUI).
//               Optional macro ILLEGAL_TRAP_EN: illegal instructions halt
//               the core instead of executing as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] imm,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal
);

    localparam logic [2:0] C_ST_FETCH  = 3'd0;
    localparam logic [2:0] C_ST_DECODE = 3'd1;
    localparam logic [2:0] C_ST_EXEC   = 3'd2;
    localparam logic [2:0] C_ST_WB     = 3'd3;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [2:0] C_ST_HALT   = 3'd4;
`endif

    localparam logic [4:0] C_OPC_OP     = 5'b01100;
    localparam logic [4:0] C_OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] C_OPC_BRANCH = 5'b11000;
    localparam logic [4:0] C_OPC_LUI    = 5'b01101;

    localparam logic [1:0] C_ALU_ADD    = 2'd0;
    localparam logic [1:0] C_ALU_SUB    = 2'd1;
    localparam logic [1:0] C_ALU_PASS_B = 2'd2;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic [31:0] w_pc_next;

    logic w_is_add;
    logic w_is_sub;
    logic w_is_addi;
    logic w_is_bne;
    logic w_is_lui;
    logic w_legal;
    logic w_rd_nonzero;

    // ------------------------------------------------------------------
    // Instruction classification; ir is stable from DECODE through WB,
    // so these decodes are valid in every post-fetch state.
    // ------------------------------------------------------------------
    always_comb begin
        w_is_add  = (r_ir[1:0] == 2'b11) && (r_ir[6:2] == C_OPC_OP)
                    && (r_ir[14:12] == 3'b000) && (r_ir[31:25] == 7'b0000000);
        w_is_sub  = (r_ir[1:0] == 2'b11) && (r_ir[6:2] == C_OPC_OP)
                    && (r_ir[14:12] == 3'b000) && (r_ir[31:25] == 7'b0100000);
        w_is_addi = (r_ir[1:0] == 2'b11) && (r_ir[6:2] == C_OPC_OPIMM)
                    && (r_ir[14:12] == 3'b000);
        w_is_bne  = (r_ir[1:0] == 2'b11) && (r_ir[6:2] == C_OPC_BRANCH)
                    && (r_ir[14:12] == 3'b001);
        w_is_lui  = (r_ir[1:0] == 2'b11) && (r_ir[6:2] == C_OPC_LUI);
        w_legal   = w_is_add || w_is_sub || w_is_addi || w_is_bne || w_is_lui;
        w_rd_nonzero = (r_ir[11:7] != 5'd0);
    end

    always_comb begin
        imm = 32'd0;
        if (w_is_addi) begin
            imm = {{20{r_ir[31]}}, r_ir[31:20]};
        end else if (w_is_bne) begin
            imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        end else if (w_is_lui) begin
            imm = {r_ir[31:12], 12'd0};
        end
    end

    always_comb begin
        alu_op      = C_ALU_ADD;
        alu_src_imm = 1'b0;
        if (w_is_sub || w_is_bne) begin
            alu_op = C_ALU_SUB;
        end else if (w_is_addi) begin
            alu_src_imm = 1'b1;
        end else if (w_is_lui) begin
            alu_op      = C_ALU_PASS_B;
            alu_src_imm = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_FETCH: begin
                if (imem_ack) begin
                    w_next_state = C_ST_DECODE;
                end
            end
            C_ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                w_next_state = w_legal ? C_ST_EXEC : C_ST_HALT;
`else
                w_next_state = C_ST_EXEC;
`endif
            end
            C_ST_EXEC: begin
                // Branches and NOP'd illegal words complete here; the rest write back
                if (w_is_bne || !w_legal) begin
                    w_next_state = C_ST_FETCH;
                end else begin
                    w_next_state = C_ST_WB;
                end
            end
            C_ST_WB: begin
                w_next_state = C_ST_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            C_ST_HALT: begin
                w_next_state = C_ST_HALT;
            end
`endif
            default: begin
                w_next_state = C_ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, all strobes gated by reset
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        if (rst_n) begin
            case (r_state)
                C_ST_FETCH: begin
                    imem_req = 1'b1;
                end
                C_ST_EXEC: begin
                    retire = w_is_bne || !w_legal;
                end
                C_ST_WB: begin
                    rf_we  = w_rd_nonzero;
                    retire = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    // The pc moves exactly when an instruction retires
    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if ((r_state == C_ST_EXEC) && w_is_bne && !alu_zero) begin
            w_pc_next = r_pc + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_instret <= 32'd0;
        end else begin
            if ((r_state == C_ST_FETCH) && imem_ack) begin
                r_ir <= imem_rdata;
            end
            if (retire) begin
                r_pc      <= w_pc_next;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if ((r_state == C_ST_DECODE) && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign ir        = r_ir;
    assign instret   = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl; retire events are
//               checked against expectations queued when each fetch is driven.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_zero;
    logic        rf_we;
    logic        retire;
    logic [31:0] instret;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        we;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .ir          (ir),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .alu_zero    (alu_zero),
        .rf_we       (rf_we),
        .retire      (retire),
        .instret     (instret),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire monitor: samples on the falling edge, before stimulus moves
    always @(negedge clk) begin
        exp_t e;
        if (retire === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_retire: unexpected retire at pc=%h", pc);
            end else begin
                e = sb.pop_front();
                if (pc !== e.pc || instret !== e.cnt || rf_we !== e.we) begin
                    errors++;
                    $display("FAIL sb_retire: got pc=%h instret=%0d rf_we=%b expected pc=%h instret=%0d rf_we=%b",
                             pc, instret, rf_we, e.pc, e.cnt, e.we);
                end
            end
        end
        if (rf_we === 1'b1 && retire !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rf_we_no_retire: rf_we=%b retire=%b", rf_we, retire);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got req=%b we=%b retire=%b expected 0 0 0", imem_req, rf_we, retire);
        end
        checks++;
        if (pc !== 32'h0 || ir !== 32'h0 || instret !== 32'h0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got pc=%h ir=%h instret=%h illegal=%b expected all 0", pc, ir, instret, illegal);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_addi();
        sb.push_back('{pc: 32'h0, cnt: 32'd0, we: 1'b1});
        imem_rdata = 32'h0050_0093;
        imem_ack   = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imm !== 32'd5 || alu_op !== 2'd0 || alu_src_imm !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL addi_decode: got imm=%h op=%0d src=%b we=%b expected 5 0 1 0", imm, alu_op, alu_src_imm, rf_we);
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL addi_exec: got we=%b retire=%b expected 0 0", rf_we, retire);
        end
        step();
        checks++;
        if (rf_we !== 1'b1) begin
            errors++;
            $display("FAIL addi_wb_cycle4: got rf_we=%b expected 1", rf_we);
        end
        step();
        checks++;
        if (pc !== 32'd4 || instret !== 32'd1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL addi_after: got pc=%h instret=%0d req=%b expected 4 1 1", pc, instret, imem_req);
        end
    endtask

    task automatic test_sub_wait();
        int we_cnt = 0;
        sb.push_back('{pc: 32'h4, cnt: 32'd1, we: 1'b1});
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                errors++;
                $display("FAIL sub_req_hold%0d: got req=%b addr=%h expected 1 00000004", i, imem_req, imem_addr);
            end
            if (i == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h4020_81B3;
            end
            step();
        end
        // ack during DECODE must be ignored
        imem_rdata = 32'hFFFF_FFFF;
        checks++;
        if (ir !== 32'h4020_81B3 || alu_op !== 2'd1 || alu_src_imm !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL sub_decode: got ir=%h op=%0d src=%b req=%b expected 402081b3 1 0 0", ir, alu_op, alu_src_imm, imem_req);
        end
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (rf_we === 1'b1) we_cnt++;
            step();
        end
        checks++;
        if (we_cnt != 1 || ir !== 32'h4020_81B3 || pc !== 32'd8 || instret !== 32'd2) begin
            errors++;
            $display("FAIL sub_after: got we_cnt=%0d ir=%h pc=%h instret=%0d expected 1 402081b3 8 2", we_cnt, ir, pc, instret);
        end
    endtask

    task automatic test_bne();
        for (int z = 0; z < 2; z++) begin
            do_reset();
            alu_zero = (z == 1);
            sb.push_back('{pc: 32'h0, cnt: 32'd0, we: 1'b0});
            imem_rdata = 32'h0020_9463;
            imem_ack   = 1'b1;
            step();
            imem_ack = 1'b0;
            checks++;
            if (imm !== 32'd8 || alu_op !== 2'd1 || alu_src_imm !== 1'b0) begin
                errors++;
                $display("FAIL bne_decode%0d: got imm=%h op=%0d src=%b expected 8 1 0", z, imm, alu_op, alu_src_imm);
            end
            step();
            checks++;
            if (retire !== 1'b1 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL bne_exec%0d: got retire=%b we=%b expected 1 0", z, retire, rf_we);
            end
            step();
            checks++;
            if (pc !== ((z == 1) ? 32'd4 : 32'd8) || instret !== 32'd1 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL bne_after%0d: got pc=%h instret=%0d req=%b expected %h 1 1",
                         z, pc, instret, imem_req, (z == 1) ? 32'd4 : 32'd8);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_lui_addi_x0();
        sb.push_back('{pc: 32'h4, cnt: 32'd1, we: 1'b1});
        imem_rdata = 32'h1234_52B7;
        imem_ack   = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imm !== 32'h1234_5000 || alu_op !== 2'd2 || alu_src_imm !== 1'b1) begin
            errors++;
            $display("FAIL lui_decode: got imm=%h op=%0d src=%b expected 12345000 2 1", imm, alu_op, alu_src_imm);
        end
        step();
        step();
        step();
        checks++;
        if (pc !== 32'd8 || instret !== 32'd2) begin
            errors++;
            $display("FAIL lui_after: got pc=%h instret=%0d expected 8 2", pc, instret);
        end
        sb.push_back('{pc: 32'h8, cnt: 32'd2, we: 1'b0});
        imem_rdata = 32'h0000_0013;
        imem_ack   = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++;
        if (imm !== 32'd0 || alu_op !== 2'd0 || alu_src_imm !== 1'b1) begin
            errors++;
            $display("FAIL nop_decode: got imm=%h op=%0d src=%b expected 0 0 1", imm, alu_op, alu_src_imm);
        end
        step();
        step();
        checks++;
        if (rf_we !== 1'b0 || retire !== 1'b1) begin
            errors++;
            $display("FAIL nop_wb: got we=%b retire=%b expected 0 1", rf_we, retire);
        end
        step();
        checks++;
        if (pc !== 32'd12 || instret !== 32'd3) begin
            errors++;
            $display("FAIL nop_after: got pc=%h instret=%0d expected c 3", pc, instret);
        end
    endtask

    task automatic test_reset_in_exec();
        alu_zero   = 1'b0;
        imem_rdata = 32'h0020_9463;
        imem_ack   = 1'b1;
        step();
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (retire !== 1'b0 || imem_req !== 1'b0 || rf_we !== 1'b0 || pc !== 32'd12) begin
            errors++;
            $display("FAIL rstexec_gate: got retire=%b req=%b we=%b pc=%h expected 0 0 0 c", retire, imem_req, rf_we, pc);
        end
        step();
        checks++;
        if (pc !== 32'h0 || instret !== 32'h0 || ir !== 32'h0) begin
            errors++;
            $display("FAIL rstexec_regs: got pc=%h instret=%0d ir=%h expected 0 0 0", pc, instret, ir);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstexec_fetch: got req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_illegal();
        imem_rdata = 32'h0000_0000;
`ifdef ILLEGAL_TRAP_EN
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (illegal !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || retire !== 1'b0 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL illegal_halt%0d: got ill=%b pc=%h req=%b retire=%b we=%b expected 1 0 0 0 0",
                         i, illegal, pc, imem_req, retire, rf_we);
            end
            step();
        end
        do_reset();
        checks++;
        if (illegal !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL illegal_exit: got ill=%b req=%b expected 0 1", illegal, imem_req);
        end
`else
        sb.push_back('{pc: 32'h0, cnt: 32'd0, we: 1'b0});
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        checks++;
        if (retire !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_nop_exec: got retire=%b ill=%b expected 1 0", retire, illegal);
        end
        step();
        checks++;
        if (pc !== 32'd4 || instret !== 32'd1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL illegal_nop_after: got pc=%h instret=%0d req=%b expected 4 1 1", pc, instret, imem_req);
        end
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        alu_zero   = 1'b0;
        test_reset();
        test_addi();
        test_sub_wait();
        test_bne();
        test_lui_addi_x0();
        test_reset_in_exec();
        test_illegal();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending retires expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  fetch request, held until accepted.
REQ-005 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  fetch accept, rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port pc  output  32  current program counter.
REQ-009 SHALL have port ir  output  32  latched instruction register.
REQ-010 SHALL have port imm  output  32  sign-extended immediate for the latched instruction.
REQ-011 SHALL have port alu_op  output  2  0=ADD, 1=SUB, 2=PASS_B.
REQ-012 SHALL have port alu_src_imm  output  1  ALU operand B: 1=imm, 0=rs2.
REQ-013 SHALL have port alu_zero  input  1  ALU result equals zero.
REQ-014 SHALL have port rf_we  output  1  register-file write strobe.
REQ-015 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-016 SHALL have port instret  output  32  retired-instruction count.
REQ-017 SHALL have port illegal  output  1  trap flag (ILLEGAL_TRAP_EN only; tied 0 otherwise).

Function
REQ-018 SHALL implement FSM states FETCH, DECODE, EXEC, WB, plus HALT when ILLEGAL_TRAP_EN is defined.
REQ-019 SHALL in FETCH assert imem_req with imem_addr=pc stable; on imem_req&imem_ack latch ir<=imem_rdata and go to DECODE; otherwise stay in FETCH.
REQ-020 SHALL ignore imem_ack outside FETCH.
REQ-021 SHALL in DECODE, one cycle, classify ir; legal set: bits[1:0]=11 and opcode[6:2] OP (funct3 000, funct7 0000000 ADD / 0100000 SUB), OPIMM (funct3 000 ADDI), BRANCH (funct3 001 BNE), LUI; all else illegal.
REQ-022 SHALL drive imm as I-type for OPIMM, B-type for BRANCH, U-type for LUI, zero for OP; stable from DECODE through WB.
REQ-023 SHALL drive alu_op/alu_src_imm: ADD 0/0, SUB 1/0, ADDI 0/1, BNE 1/0, LUI 2/1.
REQ-024 SHALL in EXEC for BNE set pc<=pc+imm if alu_zero=0, else pc<=pc+4; assert retire; return to FETCH (3 cycles with zero-wait ack).
REQ-025 SHALL in EXEC for non-branch legal instructions go to WB; in WB assert rf_we, pc<=pc+4, assert retire, return to FETCH (4 cycles with zero-wait ack).
REQ-026 SHALL suppress rf_we when ir[11:7]=0 (rd=x0); pc and retire unaffected.
REQ-027 SHALL hold rf_we, retire low in all states other than WB/EXEC as above; rf_we never asserted in EXEC.
REQ-028 SHALL increment instret on each retire, wrapping 32'hFFFF_FFFF->0.
REQ-029 SHALL compute pc arithmetic modulo 2^32; no alignment check on branch target.

Reset
REQ-030 SHALL, when rst_n=0 at a rising edge in any state, set state=FETCH, pc=RESET_PC, ir=0, instret=0, illegal=0.
REQ-031 SHALL gate imem_req, rf_we, retire to 0 while rst_n=0; an in-flight fetch is abandoned and reissued at RESET_PC.

Configuration
REQ-032 SHALL, with ILLEGAL_TRAP_EN defined, move an illegal instruction from DECODE to HALT: illegal=1, pc holds faulting address, no retire, no rf_we, imem_req=0, exit only by reset.
REQ-033 SHALL, without ILLEGAL_TRAP_EN, execute an illegal instruction as NOP: no rf_we, pc<=pc+4 and retire in EXEC, illegal tied 0, no HALT state.

Verification
REQ-034 SHALL cover: reset, imem_rdata=0x00500093 (ADDI x1,x0,5), ack in first FETCH cycle -> rf_we in cycle 4, alu_op=0, alu_src_imm=1, imm=5, pc 0->4, instret=1.
REQ-035 SHALL cover: 0x402081B3 (SUB x3,x1,x2) with ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, alu_op=1, alu_src_imm=0, rf_we once.
REQ-036 SHALL cover: 0x00209463 (BNE x1,x2,+8) at pc=0: alu_zero=0 -> pc=8; alu_zero=1 -> pc=4; rf_we never asserted; retire in EXEC.
REQ-037 SHALL cover: 0x123452B7 (LUI x5) -> imm=0x12345000, alu_op=2; then 0x00000013 (ADDI x0) -> rf_we stays 0, pc+4, retire=1.
REQ-038 SHALL cover: 0x00000000 -> with ILLEGAL_TRAP_EN illegal=1, pc frozen, imem_req=0 for 10 cycles; without, pc+4, instret+1.
REQ-039 SHALL cover: rst_n=0 for one cycle during EXEC of BNE -> pc=RESET_PC, instret=0, next cycle FETCH with imem_req=1.
